// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage controller that splits 32-bit loads and stores into
//               two wait-stated 16-bit SRAM accesses, stalling via ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_wr;
    logic [ADDR_W-2:0]  r_word;
    logic [31:0]        r_wdata;
    logic [15:0]        r_low_buf;
    logic [31:0]        r_rdata;

    logic               w_req;
    logic               w_last;
    logic [31:0]        w_diff;
    logic               w_unused;

    assign w_req    = wr_en | rd_en;
    assign w_last   = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
    // Word index is the modular offset from BASE_ADDR; only the bits that
    // reach the SRAM address are kept.
    assign w_diff   = address - 32'(BASE_ADDR);
    assign w_unused = ^{w_diff[31:ADDR_W+1], w_diff[1:0]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req)  w_next = LOW;
            LOW:     if (w_last) w_next = HIGH;
            HIGH:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_wr   <= 1'b0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_low_buf <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        r_is_wr <= wr_en;
                        r_word  <= w_diff[ADDR_W:2];
                        r_wdata <= wdata;
                    end
                end
                LOW: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) r_low_buf <= sram_rdata;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (!r_is_wr) r_rdata <= {sram_rdata, r_low_buf};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign ready = (r_state == DONE) || ((r_state == IDLE) && !w_req);
    assign rdata = r_rdata;

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        if ((r_state == LOW) || (r_state == HIGH)) begin
            sram_addr  = {r_word, (r_state == HIGH)};
            sram_wdata = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
            sram_we_n  = !r_is_wr;
            sram_oe_n  = r_is_wr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl against a word-level
//               memory model and a per-cycle expected SRAM strobe pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int W    = 2;
    localparam int BASE = 1024;
    localparam int AW   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [31:0]   address, wdata, rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata, sram_rdata;
    logic          sram_we_n, sram_oe_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:127];
    logic [31:0] exp_rdata;

    mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_wdata;
    end

    // One complete access: request cycle, 2*W SRAM cycles, DONE cycle.
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] data, input bit hold, input string tag);
        bit          is_wr;
        logic [31:0] idx;
        logic [AW-1:0] exp_a;
        logic [15:0] exp_d;
        is_wr = wr;
        idx   = (addr - 32'(BASE)) >> 2;
        wr_en = wr; rd_en = rd; address = addr; wdata = data;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s.req_ready: got %b expected 0", tag, ready);
        end
        @(posedge clk); #1;
        if (!hold) begin
            wr_en = 1'b0; rd_en = 1'b0; address = $urandom; wdata = $urandom;
        end
        for (int i = 0; i < 2 * W; i++) begin
            exp_a = AW'(idx * 2 + ((i >= W) ? 1 : 0));
            exp_d = (i >= W) ? data[31:16] : data[15:0];
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0 || sram_addr !== exp_a ||
                sram_we_n !== !is_wr || sram_oe_n !== is_wr ||
                (is_wr && sram_wdata !== exp_d)) begin
                n_fail++;
                $display("FAIL %s.cycle%0d: got rdy=%b a=%h d=%h we_n=%b oe_n=%b expected rdy=0 a=%h d=%h we_n=%b oe_n=%b",
                         tag, i, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n,
                         exp_a, exp_d, !is_wr, is_wr);
            end
            @(posedge clk); #1;
        end
        if (is_wr) ref_mem[idx[6:0]] = data;
        else       exp_rdata = ref_mem[idx[6:0]];
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s.done: got rdy=%b we_n=%b oe_n=%b rdata=%h expected rdy=1 we_n=1 oe_n=1 rdata=%h",
                     tag, ready, sram_we_n, sram_oe_n, rdata, exp_rdata);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || rdata !== exp_rdata || sram_addr !== '0 ||
            sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s.idle: got rdy=%b rdata=%h a=%h we_n=%b oe_n=%b expected rdy=1 rdata=%h a=0 we_n=1 oe_n=1",
                     tag, ready, rdata, sram_addr, sram_we_n, sram_oe_n, exp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = '0;
        check_idle("reset");
    endtask

    task automatic test_write();
        do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, "write");
        check_idle("write_after");
    endtask

    task automatic test_read();
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "read");
        n_checks++;
        if (exp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read.model: got %h expected deadbeef", exp_rdata);
        end
        check_idle("read_hold");
        check_idle("read_hold2");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, "b2b_rd");
        do_access(1'b1, 1'b0, 32'd1032, 32'hA5A5_5A5A, 1'b1, "b2b_wr");
        check_idle("b2b_after");
    endtask

    task automatic test_simultaneous();
        do_access(1'b1, 1'b1, 32'd1024, 32'h1357_9BDF, 1'b0, "both");
        check_idle("both_after");
    endtask

    task automatic test_wrap();
        // Address below BASE wraps to word 0x3FFFFFFF -> SRAM 0x3FFFE/0x3FFFF.
        do_access(1'b1, 1'b0, 32'd1020, 32'hCAFE_F00D, 1'b0, "wrap_wr");
        do_access(1'b0, 1'b1, 32'd1022, 32'h0, 1'b0, "wrap_rd");
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          w;
        for (int n = 0; n < 24; n++) begin
            a = 32'(BASE) + 32'($urandom_range(0, 120)) * 4 + 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 1) == 1);
            do_access(w, !w | ($urandom_range(0, 3) == 0), a, $urandom,
                      ($urandom_range(0, 1) == 1), "random");
            if ($urandom_range(0, 1) == 1) check_idle("random_gap");
        end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028; wdata = '0;
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (2 * W - 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = '0;
        check_idle("rst_mid");
        check_idle("rst_mid2");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'($urandom);
        for (int i = 0; i < 128; i++) ref_mem[i] = {sram_mem[2*i+1], sram_mem[2*i]};
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the pipeline. Each 32-bit load or store is split into two 16-bit accesses on an external SRAM, with a programmable number of wait states per half. The block holds `ready` low while an access is in flight; top level drives the pipeline `freeze` (including the MEM/WB register) from `~ready`. Read data goes to the MEM/WB register's `Mem_read_value_in`.

Parameters:
- WAIT_CYCLES, 2, cycles per 16-bit SRAM half-access (legal range >= 1)
- BASE_ADDR, 1024, byte address mapped to SRAM word 0
- ADDR_W, 18, SRAM address width (16-bit locations)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  store request from EXE/MEM
- rd_en  in  1  load request from EXE/MEM
- address  in  32  byte address (ALU result)
- wdata  in  32  store data
- rdata  out  32  load data, registered
- ready  out  1  1 = no access pending or access completing this cycle
- sram_addr  out  ADDR_W  SRAM halfword address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- States: IDLE, LOW, HIGH, DONE. Wait counter is wide enough for WAIT_CYCLES-1.
- rst: state=IDLE, counter=0, rdata=0, latched op/addr/data=0. Reset mid-access aborts immediately; no further strobes are driven.
- IDLE, wr_en|rd_en=1:
  - Latch op (write wins if both are set), word index = (address - BASE_ADDR) >> 2 (modular 32-bit subtract, no range check), and wdata.
  - Go to LOW with counter=0.
- IDLE, no request: stay in IDLE.
- LOW: counter increments each cycle. At counter=WAIT_CYCLES-1, capture sram_rdata into low buffer (read op only), reset counter, go to HIGH.
- HIGH: same counting rule. At the last cycle, rdata <= {sram_rdata, low_buffer} (read op only; writes leave rdata unchanged), then go to DONE.
- DONE: one cycle, unconditionally returns to IDLE. rdata holds until the next read completes.
- ready (combinational) = (state==DONE) | (state==IDLE & ~wr_en & ~rd_en).
  - Request seen in IDLE: ready=0 that cycle, through all LOW/HIGH cycles, then 1 in DONE.
  - Freeze length = 2*WAIT_CYCLES+1 cycles.
- Back-to-back requests: a request present in the IDLE cycle after DONE starts a new access. Minimum gap between accesses is that one IDLE cycle.
- Request inputs change after latching: ignored. The access completes with the latched values.
- SRAM outputs (combinational from state and latched regs):
  - LOW: sram_addr = {word_index[ADDR_W-2:0], 1'b0}.
  - HIGH: sram_addr = {word_index[ADDR_W-2:0], 1'b1}.
  - Write op: sram_we_n=0 in every LOW/HIGH cycle; sram_wdata = wdata[15:0] in LOW, wdata[31:16] in HIGH.
  - Read op: sram_oe_n=0 in every LOW/HIGH cycle.
  - IDLE/DONE/reset: sram_addr=0, sram_wdata=0, sram_we_n=1, sram_oe_n=1.
  - sram_we_n and sram_oe_n are never both 0.

Test Plan:
- Reset defaults: rst=1 for 2 cycles -> rdata=0, ready=1, sram_we_n=1, sram_oe_n=1, sram_addr=0.
- Write (W=2, BASE=1024): wr_en=1, address=1028, wdata=0xDEADBEEF ->
  - ready=0 for 5 cycles, then 1 in DONE.
  - sram_addr=2 with sram_wdata=0xBEEF, sram_we_n=0 for 2 cycles.
  - Then sram_addr=3 with sram_wdata=0xDEAD for 2 cycles.
- Read: SRAM model returns 0xBEEF at addr 2 and 0xDEAD at addr 3. rd_en=1, address=1028 ->
  - sram_oe_n=0 for 4 cycles.
  - rdata=0xDEADBEEF in the DONE cycle; held afterwards.
- Back-to-back with W=1: read 1024 then write 1032, requests held while ready=0 ->
  - Each access has ready=0 for 3 cycles.
  - Second access starts 1 cycle after the first access's DONE cycle.
  - sram_addr sequence 0, 1, then 4, 5.
- Simultaneous wr_en=rd_en=1, address=1024 -> write performed (sram_we_n=0, sram_oe_n=1 throughout); rdata unchanged.
- Reset mid-access: assert rst during the 2nd HIGH cycle of a read -> next cycle: IDLE, rdata=0, strobes inactive, ready=1 with requests low.
